// File: rtl/rv32i_ctrl_alu_mem.sv
// Single-cycle RV32I slice: main/ALU decode, ALU with flags, branch resolve,
// word-addressed data memory and write-back select. Only the memory holds state.
module rv32i_ctrl_alu_mem #(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        a_rst,
  input  logic [6:0]  op,
  input  logic [2:0]  funct3,
  input  logic        funct7,
  input  logic [31:0] SrcA,
  input  logic [31:0] WriteData,
  input  logic [31:0] ImmExt,
  output logic        PCSrc,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        ALUSrc,
  output logic        ResultSrc,
  output logic [1:0]  ImmSrc,
  output logic [2:0]  ALUControl,
  output logic [31:0] ALUResult,
  output logic        zero,
  output logic        sign_flag,
  output logic [31:0] ReadData,
  output logic [31:0] Result
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  localparam logic [2:0] C_ADD = 3'b000, C_SUB = 3'b001, C_AND = 3'b010,
                         C_OR  = 3'b011, C_XOR = 3'b100, C_SLT = 3'b101,
                         C_SLL = 3'b110, C_SRL = 3'b111;

  logic          branch;
  aluop_e        aluop;
  logic [31:0]   srcb;
  logic          cond;
  logic [AW-1:0] addr;
  logic [31:0]   mem [DEPTH];

  // main decoder: unknown opcodes leave every strobe low
  always_comb begin
    RegWrite  = 1'b0;
    ImmSrc    = 2'b00;
    ALUSrc    = 1'b0;
    MemWrite  = 1'b0;
    ResultSrc = 1'b0;
    branch    = 1'b0;
    aluop     = ALUOP_ADD;
    case (op)
      7'b0000011: begin RegWrite = 1'b1; ALUSrc = 1'b1; ResultSrc = 1'b1; end
      7'b0100011: begin ImmSrc = 2'b01; ALUSrc = 1'b1; MemWrite = 1'b1; end
      7'b0110011: begin RegWrite = 1'b1; aluop = ALUOP_FUNCT; end
      7'b0010011: begin RegWrite = 1'b1; ALUSrc = 1'b1; aluop = ALUOP_FUNCT; end
      7'b1100011: begin ImmSrc = 2'b10; branch = 1'b1; aluop = ALUOP_SUB; end
      default: ;
    endcase
  end

  // ALU decoder; funct7 only turns add into sub for R-type, srl stays logical
  always_comb begin
    ALUControl = C_ADD;
    case (aluop)
      ALUOP_SUB:   ALUControl = C_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  ALUControl = (op == 7'b0110011 && funct7) ? C_SUB : C_ADD;
          3'b001:  ALUControl = C_SLL;
          3'b010:  ALUControl = C_SLT;
          3'b100:  ALUControl = C_XOR;
          3'b101:  ALUControl = C_SRL;
          3'b110:  ALUControl = C_OR;
          3'b111:  ALUControl = C_AND;
          default: ALUControl = C_ADD;
        endcase
      end
      default: ALUControl = C_ADD;
    endcase
  end

  assign srcb = ALUSrc ? ImmExt : WriteData;

  // ALU datapath
  always_comb begin
    ALUResult = 32'd0;
    case (ALUControl)
      C_ADD: ALUResult = SrcA + srcb;
      C_SUB: ALUResult = SrcA - srcb;
      C_AND: ALUResult = SrcA & srcb;
      C_OR:  ALUResult = SrcA | srcb;
      C_XOR: ALUResult = SrcA ^ srcb;
      C_SLT: ALUResult = {31'd0, $signed(SrcA) < $signed(srcb)};
      C_SLL: ALUResult = SrcA << srcb[4:0];
      C_SRL: ALUResult = SrcA >> srcb[4:0];
      default: ALUResult = 32'd0;
    endcase
  end

  assign zero      = (ALUResult == 32'd0);
  assign sign_flag = ALUResult[31];

  // branch condition; blt trusts the raw sign bit of the subtraction
  always_comb begin
    cond = 1'b0;
    case (funct3)
      3'b000:  cond = zero;
      3'b001:  cond = ~zero;
      3'b100:  cond = sign_flag;
      default: cond = 1'b0;
    endcase
  end

  assign PCSrc = branch & cond;

  // word index wraps modulo DEPTH; byte offset bits are dropped
  assign addr = AW'({2'b00, ALUResult[31:2]} % 32'(DEPTH));

  // data memory: async clear wins over any write
  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'd0;
    end else if (MemWrite) begin
      mem[addr] <= WriteData;
    end
  end

  assign ReadData = mem[addr];
  assign Result   = ResultSrc ? ReadData : ALUResult;

endmodule

// File: tb/tb_rv32i_ctrl_alu_mem.sv
// Randomized + directed bench; driver pushes expected responses, monitor checks.
module tb_rv32i_ctrl_alu_mem;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        a_rst = 1'b0;
  logic [6:0]  op = '0;
  logic [2:0]  funct3 = '0;
  logic        funct7 = 1'b0;
  logic [31:0] SrcA = '0, WriteData = '0, ImmExt = '0;
  logic        PCSrc, RegWrite, MemWrite, ALUSrc, ResultSrc, zero, sign_flag;
  logic [1:0]  ImmSrc;
  logic [2:0]  ALUControl;
  logic [31:0] ALUResult, ReadData, Result;

  rv32i_ctrl_alu_mem #(.DEPTH(DEPTH)) dut (
    .clk(clk), .a_rst(a_rst), .op(op), .funct3(funct3), .funct7(funct7),
    .SrcA(SrcA), .WriteData(WriteData), .ImmExt(ImmExt),
    .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite), .ALUSrc(ALUSrc),
    .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
    .ALUResult(ALUResult), .zero(zero), .sign_flag(sign_flag),
    .ReadData(ReadData), .Result(Result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu, rd, res;
    logic [2:0]  ctl;
    logic [1:0]  imms;
    logic        pcsrc, regw, memw, alusrc, ressrc, zf, sf;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] mdl_mem [DEPTH];
  logic        vld = 1'b0;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // instruction-level reference: what each instruction means, not how it is decoded
  function automatic exp_t model(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                                 input logic [31:0] a, input logic [31:0] wd,
                                 input logic [31:0] imm);
    exp_t e;
    string nm;
    logic [31:0] b;
    e = '{alu: 0, rd: 0, res: 0, ctl: 0, imms: 0, pcsrc: 0, regw: 0, memw: 0,
          alusrc: 0, ressrc: 0, zf: 0, sf: 0};
    nm = "add";
    b  = wd;
    if (o == 7'b0000011) begin e.regw = 1; e.alusrc = 1; e.ressrc = 1; b = imm; end
    else if (o == 7'b0100011) begin e.imms = 2'b01; e.alusrc = 1; e.memw = 1; b = imm; end
    else if (o == 7'b1100011) begin e.imms = 2'b10; nm = "sub"; end
    else if (o == 7'b0110011 || o == 7'b0010011) begin
      e.regw = 1;
      if (o == 7'b0010011) begin e.alusrc = 1; b = imm; end
      case (f3)
        3'd0: nm = (o == 7'b0110011 && f7) ? "sub" : "add";
        3'd1: nm = "sll";
        3'd2: nm = "slt";
        3'd4: nm = "xor";
        3'd5: nm = "srl";
        3'd6: nm = "or";
        3'd7: nm = "and";
        default: nm = "add";
      endcase
    end
    case (nm)
      "add": begin e.alu = a + b; e.ctl = 3'b000; end
      "sub": begin e.alu = a - b; e.ctl = 3'b001; end
      "and": begin e.alu = a & b; e.ctl = 3'b010; end
      "or":  begin e.alu = a | b; e.ctl = 3'b011; end
      "xor": begin e.alu = a ^ b; e.ctl = 3'b100; end
      "slt": begin e.alu = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; e.ctl = 3'b101; end
      "sll": begin e.alu = a << (b % 32); e.ctl = 3'b110; end
      default: begin e.alu = a >> (b % 32); e.ctl = 3'b111; end
    endcase
    e.zf = (e.alu == 0);
    e.sf = e.alu[31];
    if (o == 7'b1100011)
      e.pcsrc = (f3 == 3'd0) ? e.zf : (f3 == 3'd1) ? !e.zf : (f3 == 3'd4) ? e.sf : 1'b0;
    e.rd  = mdl_mem[(e.alu / 4) % DEPTH];
    e.res = e.ressrc ? e.rd : e.alu;
    return e;
  endfunction

  // drive one instruction just after an edge; reset level applied at the same time
  task automatic apply(input logic rst, input logic [6:0] o, input logic [2:0] f3,
                       input logic f7, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] imm);
    exp_t e;
    @(posedge clk);
    #1;
    a_rst = rst;
    if (!rst) for (int i = 0; i < DEPTH; i++) mdl_mem[i] = 32'd0;
    op = o; funct3 = f3; funct7 = f7; SrcA = a; WriteData = wd; ImmExt = imm;
    e = model(o, f3, f7, a, wd, imm);
    sbq.push_back(e);
    vld = 1'b1;
    if (e.memw && rst) mdl_mem[(e.alu / 4) % DEPTH] = wd;
  endtask

  // monitor: compare at the falling edge, well away from the write edge
  always @(negedge clk) begin
    exp_t e;
    if (vld) begin
      if (sbq.size() == 0) begin
        checks++; errors++;
        $display("FAIL scoreboard_empty got 0 entries expected 1");
      end else begin
        e = sbq.pop_front();
        chk("RegWrite",   {31'd0, RegWrite},   {31'd0, e.regw});
        chk("MemWrite",   {31'd0, MemWrite},   {31'd0, e.memw});
        chk("ALUSrc",     {31'd0, ALUSrc},     {31'd0, e.alusrc});
        chk("ResultSrc",  {31'd0, ResultSrc},  {31'd0, e.ressrc});
        chk("ImmSrc",     {30'd0, ImmSrc},     {30'd0, e.imms});
        chk("ALUControl", {29'd0, ALUControl}, {29'd0, e.ctl});
        chk("ALUResult",  ALUResult,           e.alu);
        chk("zero",       {31'd0, zero},       {31'd0, e.zf});
        chk("sign_flag",  {31'd0, sign_flag},  {31'd0, e.sf});
        chk("PCSrc",      {31'd0, PCSrc},      {31'd0, e.pcsrc});
        chk("ReadData",   ReadData,            e.rd);
        chk("Result",     Result,              e.res);
      end
    end
  end

  initial begin
    logic [6:0] o;
    logic [6:0] ops [5];
    ops[0] = 7'b0000011; ops[1] = 7'b0100011; ops[2] = 7'b0110011;
    ops[3] = 7'b0010011; ops[4] = 7'b1100011;
    for (int i = 0; i < DEPTH; i++) mdl_mem[i] = 32'd0;
    // reset state: memory reads zero while held in reset
    apply(1'b0, 7'b0000011, 3'd2, 1'b0, 32'h0000_0040, 32'd0, 32'd4);
    // directed cases from the block's reference scenarios
    apply(1'b1, 7'b0110011, 3'd0, 1'b1, 32'd10, 32'd3, 32'd0);
    apply(1'b1, 7'b0100011, 3'd2, 1'b0, 32'h100, 32'hDEADBEEF, 32'd4);
    apply(1'b1, 7'b0000011, 3'd2, 1'b0, 32'h100, 32'd0, 32'd4);
    apply(1'b1, 7'b1100011, 3'd0, 1'b0, 32'd5, 32'd5, 32'd0);
    apply(1'b1, 7'b1100011, 3'd1, 1'b0, 32'd5, 32'd5, 32'd0);
    apply(1'b1, 7'b1100011, 3'd4, 1'b0, 32'hFFFF_FFFF, 32'd2, 32'd0);
    apply(1'b1, 7'b0010011, 3'd2, 1'b0, 32'hFFFF_FFFB, 32'd0, 32'd3);
    apply(1'b1, 7'b0010011, 3'd1, 1'b0, 32'd1, 32'd0, 32'd35);
    apply(1'b1, 7'b0010011, 3'd5, 1'b1, 32'h8000_0000, 32'd0, 32'd4);
    apply(1'b1, 7'b1111111, 3'd0, 1'b1, 32'd7, 32'd9, 32'd1);
    // reset mid-operation, and a write attempted under reset
    apply(1'b1, 7'b0100011, 3'd2, 1'b0, 32'd0, 32'h1234, 32'd0);
    apply(1'b1, 7'b0000011, 3'd2, 1'b0, 32'd0, 32'd0, 32'd0);
    apply(1'b0, 7'b0000011, 3'd2, 1'b0, 32'd0, 32'd0, 32'd0);
    apply(1'b0, 7'b0100011, 3'd2, 1'b0, 32'd0, 32'h5555, 32'd0);
    apply(1'b1, 7'b0000011, 3'd2, 1'b0, 32'd0, 32'd0, 32'd0);
    // randomized traffic; loads/stores kept to a small window so they alias
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a, wd, imm;
      int k;
      k = $urandom_range(0, 5);
      if (k < 5) o = ops[k];
      else begin
        o = 7'($urandom);
        while (o == ops[0] || o == ops[1] || o == ops[2] || o == ops[3] || o == ops[4])
          o = 7'($urandom);
      end
      a   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) : $urandom;
      wd  = ($urandom_range(0, 3) == 0) ? a : $urandom;
      imm = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      if (o == ops[0] || o == ops[1]) begin
        a   = 32'($urandom_range(0, 600));
        imm = 32'($urandom_range(0, 16));
      end
      apply(($urandom_range(0, 99) != 0), o, 3'($urandom), 1'($urandom), a, wd, imm);
    end
    @(posedge clk);
    #1;
    vld = 1'b0;
    // drain bound: scoreboard must be empty within a few cycles
    for (int w = 0; w < 10 && sbq.size() != 0; w++) @(posedge clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d entries expected 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
